// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: serializes WIDTH-bit frames with GAP idle cycles after each
// frame and counts "101" patterns on the transmitted bit stream (saturating at 255).
module serial_pattern_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned GAP       = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [7:0]       hit_cnt
);

    localparam int unsigned     CntW    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
    localparam logic [3:0]      LastGap = 4'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [CntW-1:0]  cnt_q;
    logic [3:0]       gap_q;
    logic [1:0]       hist_q;
    logic [7:0]       hit_cnt_q;
    logic             out_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             in_ready_q;

    logic [WIDTH-1:0] shift_nxt;
    logic             hit;

    function automatic logic head_of(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    always_comb begin
        if (MSB_FIRST) begin
            shift_nxt = {shift_q[WIDTH-2:0], 1'b0};
        end else begin
            shift_nxt = {1'b0, shift_q[WIDTH-1:1]};
        end
        // hist_q[1] is the older bit; out_q is the bit on the wire this cycle
        hit = (hist_q == 2'b10) && out_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            hist_q      <= '0;
            hit_cnt_q   <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        state_q     <= StShift;
                        shift_q     <= in_data;
                        cnt_q       <= '0;
                        hist_q      <= '0;
                        out_q       <= head_of(in_data);
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        in_ready_q  <= 1'b0;
                    end
                end
                StShift: begin
                    if (hit && (hit_cnt_q != 8'hFF)) begin
                        hit_cnt_q <= hit_cnt_q + 8'd1;
                    end
                    hist_q  <= {hist_q[0], out_q};
                    shift_q <= shift_nxt;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        out_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b0;
                        gap_q       <= '0;
                        if (GAP > 0) begin
                            state_q <= StGap;
                        end else begin
                            state_q    <= StIdle;
                            busy_q     <= 1'b0;
                            in_ready_q <= 1'b1;
                        end
                    end else begin
                        out_q  <= head_of(shift_nxt);
                        done_q <= ((cnt_q + 1'b1) == LastCnt);
                    end
                end
                StGap: begin
                    gap_q <= gap_q + 1'b1;
                    if (gap_q == LastGap) begin
                        state_q    <= StIdle;
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_q       <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: three instances (default, LSB-first, zero gap) checked with a
// fixed vector table, hand-written corner sequences and random stimulus against a frame model.
module tb_serial_pattern_tx;

    localparam int W  = 8;
    localparam int NI = 3;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       o;
        logic       ov;
        logic       dn;
        logic       b;
        logic       r;
        logic [7:0] h;
    } vec_t;

    logic       clk = 1'b0;
    logic [2:0] rst;
    logic [2:0] vld;
    logic [7:0] din [NI];
    wire  [2:0] rdy;
    wire  [2:0] so;
    wire  [2:0] ov;
    wire  [2:0] bsy;
    wire  [2:0] dn;
    wire  [7:0] hc [NI];

    int n_vec = 0;
    int n_err = 0;

    // Frame model: pos 0 = idle, 1..W = frame bit pos-1 on the wire, W+1..W+gap = gap cycles
    int         pos   [NI];
    logic [7:0] mdat  [NI];
    int         mhits [NI];

    serial_pattern_tx #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .rst(rst[0]), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .out(so[0]), .out_valid(ov[0]), .busy(bsy[0]), .done(dn[0]), .hit_cnt(hc[0])
    );

    serial_pattern_tx #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .rst(rst[1]), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .out(so[1]), .out_valid(ov[1]), .busy(bsy[1]), .done(dn[1]), .hit_cnt(hc[1])
    );

    serial_pattern_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1)) u_dut_gap0 (
        .clk(clk), .rst(rst[2]), .in_data(din[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
        .out(so[2]), .out_valid(ov[2]), .busy(bsy[2]), .done(dn[2]), .hit_cnt(hc[2])
    );

    initial forever #5 clk = ~clk;

    function automatic int gap_of(input int i);
        return (i == 2) ? 0 : 2;
    endfunction

    function automatic logic mbit(input int i, input int k);
        return (i == 1) ? mdat[i][k] : mdat[i][W-1-k];
    endfunction

    function automatic vec_t mk(input int v, input int d, input int o, input int vo,
                                input int e, input int b, input int r, input int h);
        vec_t x;
        x.v  = (v != 0);
        x.d  = 8'(d);
        x.o  = (o != 0);
        x.ov = (vo != 0);
        x.dn = (e != 0);
        x.b  = (b != 0);
        x.r  = (r != 0);
        x.h  = 8'(h);
        return x;
    endfunction

    task automatic chk(input string name, input int i, input logic [7:0] act,
                       input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d t=%0t: got %0d, want %0d", name, i, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            if (rst[i]) begin
                pos[i]   = 0;
                mhits[i] = 0;
            end else begin
                if (pos[i] >= 3 && pos[i] <= W && mbit(i, pos[i] - 3) && !mbit(i, pos[i] - 2)
                    && mbit(i, pos[i] - 1) && mhits[i] < 255) begin
                    mhits[i]++;
                end
                if (pos[i] == 0) begin
                    if (vld[i]) begin
                        mdat[i] = din[i];
                        pos[i]  = 1;
                    end
                end else if (pos[i] < W + gap_of(i)) begin
                    pos[i]++;
                end else begin
                    pos[i] = 0;
                end
            end
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < NI; i++) begin
            logic on;
            on = (pos[i] >= 1 && pos[i] <= W);
            chk("out", i, 8'(so[i]), 8'(on ? mbit(i, pos[i] - 1) : 1'b0));
            chk("out_valid", i, 8'(ov[i]), 8'(on));
            chk("done", i, 8'(dn[i]), 8'(pos[i] == W));
            chk("busy", i, 8'(bsy[i]), 8'(pos[i] != 0));
            chk("in_ready", i, 8'(rdy[i]), 8'(pos[i] == 0));
            chk("hit_cnt", i, hc[i], 8'(mhits[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    vec_t       tbl [22];
    logic [7:0] seq;

    initial begin
        rst = 3'b111;
        vld = 3'b000;
        for (int i = 0; i < NI; i++) begin
            din[i]   = 8'h00;
            pos[i]   = 0;
            mhits[i] = 0;
            mdat[i]  = 8'h00;
        end

        // A5 then AA on the default instance; in_valid pulses during a frame must be ignored
        tbl[0]  = mk(1, 'hA5, 1, 1, 0, 1, 0, 0);
        tbl[1]  = mk(0, 'h00, 0, 1, 0, 1, 0, 0);
        tbl[2]  = mk(0, 'h00, 1, 1, 0, 1, 0, 0);
        tbl[3]  = mk(1, 'h00, 0, 1, 0, 1, 0, 1);
        tbl[4]  = mk(0, 'h00, 0, 1, 0, 1, 0, 1);
        tbl[5]  = mk(0, 'h00, 1, 1, 0, 1, 0, 1);
        tbl[6]  = mk(0, 'h00, 0, 1, 0, 1, 0, 1);
        tbl[7]  = mk(0, 'h00, 1, 1, 1, 1, 0, 1);
        tbl[8]  = mk(0, 'h00, 0, 0, 0, 1, 0, 2);
        tbl[9]  = mk(0, 'h00, 0, 0, 0, 1, 0, 2);
        tbl[10] = mk(0, 'h00, 0, 0, 0, 0, 1, 2);
        tbl[11] = mk(1, 'hAA, 1, 1, 0, 1, 0, 2);
        tbl[12] = mk(1, 'hFF, 0, 1, 0, 1, 0, 2);
        tbl[13] = mk(1, 'hFF, 1, 1, 0, 1, 0, 2);
        tbl[14] = mk(1, 'hFF, 0, 1, 0, 1, 0, 3);
        tbl[15] = mk(1, 'hFF, 1, 1, 0, 1, 0, 3);
        tbl[16] = mk(1, 'hFF, 0, 1, 0, 1, 0, 4);
        tbl[17] = mk(1, 'hFF, 1, 1, 0, 1, 0, 4);
        tbl[18] = mk(1, 'hFF, 0, 1, 1, 1, 0, 5);
        tbl[19] = mk(1, 'hFF, 0, 0, 0, 1, 0, 5);
        tbl[20] = mk(1, 'hFF, 0, 0, 0, 1, 0, 5);
        tbl[21] = mk(0, 'h00, 0, 0, 0, 0, 1, 5);

        // Reset state, both during and after reset
        #2;
        check_model();
        tick();
        tick();
        rst = 3'b000;
        #1;
        check_model();

        for (int k = 0; k < 22; k++) begin
            vld[0] = tbl[k].v;
            din[0] = tbl[k].d;
            tick();
            chk("tbl_out", k, 8'(so[0]), 8'(tbl[k].o));
            chk("tbl_out_valid", k, 8'(ov[0]), 8'(tbl[k].ov));
            chk("tbl_done", k, 8'(dn[0]), 8'(tbl[k].dn));
            chk("tbl_busy", k, 8'(bsy[0]), 8'(tbl[k].b));
            chk("tbl_in_ready", k, 8'(rdy[0]), 8'(tbl[k].r));
            chk("tbl_hit_cnt", k, hc[0], tbl[k].h);
        end
        vld[0] = 1'b0;

        // LSB-first: 8'h01 goes out as 1 followed by seven 0s, no hits
        seq    = 8'b1000_0000;
        vld[1] = 1'b1;
        din[1] = 8'h01;
        tick();
        vld[1] = 1'b0;
        for (int k = 0; k < W; k++) begin
            chk("lsb_out", k, 8'(so[1]), 8'(seq[7-k]));
            chk("lsb_done", k, 8'(dn[1]), 8'(k == W - 1));
            tick();
        end
        chk("lsb_out_valid_gap", 1, 8'(ov[1]), 8'd0);
        chk("lsb_hit_cnt", 1, hc[1], 8'd0);
        tick();
        tick();
        chk("lsb_in_ready", 1, 8'(rdy[1]), 8'd1);

        // Zero gap with in_valid held: acceptance every 9 cycles, one ready cycle between frames
        vld[2] = 1'b1;
        din[2] = 8'hFF;
        for (int k = 0; k < 27; k++) begin
            tick();
            chk("g0_in_ready", k, 8'(rdy[2]), 8'((k % 9) == 8));
            chk("g0_out", k, 8'(so[2]), 8'((k % 9) != 8));
            chk("g0_hit_cnt", k, hc[2], 8'd0);
        end
        vld[2] = 1'b0;
        tick();

        // Reset during the 4th bit of A5 aborts the frame immediately
        vld[0] = 1'b1;
        din[0] = 8'hA5;
        tick();
        vld[0] = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_pre_busy", 0, 8'(bsy[0]), 8'd1);
        rst[0]   = 1'b1;
        pos[0]   = 0;
        mhits[0] = 0;
        #1;
        chk("rst_out", 0, 8'(so[0]), 8'd0);
        chk("rst_out_valid", 0, 8'(ov[0]), 8'd0);
        chk("rst_busy", 0, 8'(bsy[0]), 8'd0);
        chk("rst_done", 0, 8'(dn[0]), 8'd0);
        chk("rst_in_ready", 0, 8'(rdy[0]), 8'd1);
        chk("rst_hit_cnt", 0, hc[0], 8'd0);
        tick();
        rst[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_model();
        end

        // 110 back-to-back AA frames: three hits each, saturating at 255
        for (int f = 0; f < 110; f++) begin
            vld[0] = 1'b1;
            din[0] = 8'hAA;
            tick();
            vld[0] = 1'b0;
            repeat (10) tick();
            chk("sat_hit_cnt", f, hc[0], 8'(((f + 1) * 3 > 255) ? 255 : (f + 1) * 3));
        end
        chk("sat_final", 0, hc[0], 8'd255);

        // Random traffic on all instances with occasional asynchronous resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                vld[i] = ($urandom_range(0, 3) != 0);
                din[i] = 8'($urandom());
                if (rst[i]) begin
                    rst[i] = 1'b0;
                end else if ($urandom_range(0, 199) == 0) begin
                    rst[i]   = 1'b1;
                    pos[i]   = 0;
                    mhits[i] = 0;
                end
            end
            #1;
            check_model();
            tick();
        end
        check_model();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
